tqvp_add_sequencer: RTL
=======================

# tqvp_add_sequencer

Memory-mapped TinyQV peripheral that sequences a single shared 16-bit-operand adder over a queued job. The host pushes up to 8 operands into an operand FIFO and issues START. A state machine then pops one operand per clock into a 20-bit accumulator and raises an interrupt when the FIFO drains. It sits on the standard TinyQV peripheral bus and serves as the multi-cycle controller in front of the adder datapath.

## Interface
- DEPTH, 8, operand FIFO entries (power of 2)
- ACC_W, 20, accumulator width
- clk  in  1  project clock (64 MHz nominal)
- rst_n  in  1  reset, synchronous, active-low
- ui_in  in  8  input PMOD; unused
- uo_out  out  8  {irq, busy, done, ovf_err, count[3:0]}
- address  in  6  register address
- data_in  in  32  write data; bits [15:0] used
- data_write_n  in  2  11 = none, 00 = 8b, 01 = 16b, 10 = 32b
- data_read_n  in  2  read strobe; unused, since reads have no side effects
- data_out  out  32  read data, combinational from address
- data_ready  out  1  tied 1
- user_interrupt  out  1  level irq = done flag

## Operation
- Register map:
  - 0x00 W PUSH: any write width; an 8-bit write zero-extends to 16 bits.
  - 0x00 R: {28'b0, count[3:0]}.
  - 0x04 W CTRL: bit0 START, bit1 CLEAR, bit2 KEEP (do not zero acc on START).
  - 0x04 R STATUS: {27'b0, acc_wrap, ovf_err, done, busy, full}.
  - 0x08 R RESULT: {12'b0, acc[19:0]}.
  - 0x0C W IRQCLR: bit0 = 1 clears done.
  - All other addresses read 0. Writes to them are ignored.
- FSM states:
  - IDLE: busy = 0. START with KEEP = 0 loads acc = 0 and clears acc_wrap.
    - START with count > 0 goes to RUN.
    - START with count == 0 sets done immediately and stays in IDLE.
  - RUN: busy = 1. Each cycle: pop head, acc <= acc + zero_ext(head).
    - The carry out of bit 19 sets sticky acc_wrap; acc wraps mod 2^20.
    - The pop that leaves count == 0 (with no simultaneous push) moves to IDLE and sets done on the same edge.
- Pushes:
  - Pushes are accepted in any state while not full. Pushes during RUN join the current job.
  - A simultaneous push and pop leaves count unchanged. The job continues.
  - A push when full is dropped and sets sticky ovf_err.
- START while busy is ignored.
- CLEAR in any state:
  - Flushes the FIFO (count = 0, pointers = 0).
  - Sets acc = 0.
  - Clears done, ovf_err and acc_wrap.
  - Sets FSM to IDLE. This aborts a running job with no done.
- START and CLEAR in the same write: CLEAR wins and START is ignored.
- Event on the same edge as IRQCLR:
  - done set and IRQCLR on the same edge: set wins.
  - ovf_err set and CLEAR on the same edge: CLEAR wins.
- FIFO pointers are 3 bits and wrap 7 -> 0. count is 4 bits, 0..8. full = (count == 8).

## Timing
- Reset values:
  - acc = 0, count = 0, FSM = IDLE.
  - done, ovf_err, acc_wrap = 0.
  - user_interrupt = 0, uo_out = 0x00, data_out = 0.
- data_ready is 1 always. Reads are combinational on the current register state.
- A PUSH written at edge E is visible in count after E.
- START written at edge S with N queued operands:
  - busy = 1 after S.
  - The i-th pop occurs at edge S+i.
  - On edge S+N: busy = 0, done = 1, user_interrupt = 1, RESULT final.
- Job latency is N+1 cycles from the START write cycle to done.
- Throughput is 1 operand per cycle.
- Reset asserted mid-RUN: all state returns to reset values on the next edge. No done is produced.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles -> uo_out = 0x00, STATUS = 0, RESULT = 0, user_interrupt = 0.
- Push 3, 5, 0xFFFF, then START -> busy for exactly 3 cycles; RESULT = 0x10007, done = 1, irq = 1, acc_wrap = 0; IRQCLR bit0 -> irq = 0.
- Push 9 × 0x0001 -> count = 8, full = 1, ovf_err = 1; START -> RESULT = 8 after 8 cycles.
- Accumulation with wrap:
  - Push 8 × 0xFFFF, START -> RESULT = 0x7FFF8.
  - Repeat twice with KEEP = 1 -> RESULT = 0x7FFE8 (wrapped), acc_wrap = 1.
- Push 4 operands, START, CLEAR one cycle later -> busy = 0, count = 0, RESULT = 0, done never asserts.
- START with an empty FIFO -> done = 1 on the next cycle with RESULT = 0. A push on the same edge as a pop during RUN extends the job by one cycle and sums correctly.

Source files
------------

// File: rtl/tqvp_add_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tqvp_add_sequencer
// Brief    : TinyQV peripheral that queues 16-bit operands and sums them into
//            a wrapping accumulator, one per clock, raising an irq when done.
// Revision : 1.0 - initial release
//==============================================================================

module tqvp_add_sequencer #(
    parameter int DEPTH = 8,
    parameter int ACC_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    localparam logic [5:0] ADDR_DATA   = 6'h00;
    localparam logic [5:0] ADDR_CTRL   = 6'h04;
    localparam logic [5:0] ADDR_RESULT = 6'h08;
    localparam logic [5:0] ADDR_IRQCLR = 6'h0C;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic             acc_wrap;
    logic             ovf_err;
    logic             done;

    logic             wr_en;
    logic             push_req;
    logic             ctrl_wr;
    logic             clear;
    logic             start;
    logic             keep;
    logic             irq_clr;
    logic [15:0]      push_data;
    logic             full;
    logic             busy;
    logic             pop;
    logic             push_ok;
    logic             last_pop;
    logic [15:0]      head;
    logic [ACC_W:0]   sum;
    logic             done_set;
    logic             acc_zero;
    logic             unused_inputs;

    // Bus decode: any write width counts as a write strobe.
    assign wr_en     = (data_write_n != 2'b11);
    assign push_req  = wr_en && (address == ADDR_DATA);
    assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
    assign clear     = ctrl_wr && data_in[1];
    assign start     = ctrl_wr && data_in[0] && !data_in[1];
    assign keep      = data_in[2];
    assign irq_clr   = wr_en && (address == ADDR_IRQCLR) && data_in[0];
    assign push_data = (data_write_n == 2'b00) ? {8'h00, data_in[7:0]} : data_in[15:0];

    assign full     = (count == FULL_CNT);
    assign busy     = (state == ST_RUN);
    assign pop      = busy && (count != '0);
    assign push_ok  = push_req && !full;
    assign last_pop = pop && !push_ok && (count == ONE_CNT);
    assign head     = fifo_mem[rd_ptr];
    assign sum      = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, head};
    assign acc_zero = (state == ST_IDLE) && start && !keep;

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_next = ST_RUN;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (last_pop) begin
                    state_next = ST_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Storage only; occupancy is tracked by the pointers and count below.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            acc      <= '0;
            acc_wrap <= 1'b0;
            ovf_err  <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                acc    <= sum[ACC_W-1:0];
                if (sum[ACC_W]) begin
                    acc_wrap <= 1'b1;
                end
            end else if (acc_zero) begin
                acc      <= '0;
                acc_wrap <= 1'b0;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            if (push_req && full) begin
                ovf_err <= 1'b1;
            end
            // A completion on the same edge as IRQCLR must not be lost.
            if (done_set) begin
                done <= 1'b1;
            end else if (irq_clr) begin
                done <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_DATA:   data_out = 32'(count);
            ADDR_CTRL:   data_out = {27'b0, acc_wrap, ovf_err, done, busy, full};
            ADDR_RESULT: data_out = 32'(acc);
            default:     data_out = '0;
        endcase
    end

    assign uo_out         = {done, busy, done, ovf_err, 4'(count)};
    assign user_interrupt = done;
    assign data_ready     = 1'b1;

    assign unused_inputs = &{1'b0, ui_in, data_read_n, data_in[31:16]};

endmodule

`default_nettype wire
